knight_seq: RTL and testbench
=============================

Name: knight_seq

Overview:
Sequencer for the 8-LED knight scanner core. It issues the scanner's clear and step-enable, so the scan rate, run/pause/stop and the number of round-trip sweeps are set at run time rather than tied to the raw clock. It watches the scanner's direction flag to count completed sweeps and flags completion. It sits between the top-level control inputs and the scanner instance.

Parameters:
DIV_W, 16, width of the step-rate divider input and prescaler counter
CNT_W, 8, width of the sweep target and sweep counter

Ports:
ck  in  1  system clock; all state changes on the rising edge
res  in  1  synchronous reset, active high
start  in  1  level, sampled each cycle; begin (or restart) a run
stop  in  1  level; abort the run and return to idle
pause  in  1  level; freeze stepping while high during a run
div  in  DIV_W  step period minus 1, latched at start
nsweep  in  CNT_W  round trips to run, latched at start; 0 = run forever
up_in  in  1  direction flag from the scanner (1 = moving up)
sclr  out  1  one-cycle clear pulse to the scanner
step  out  1  one-cycle step-enable pulse to the scanner
busy  out  1  high in CLR, RUN and HOLD
done  out  1  high in DONE
sweeps  out  CNT_W  completed round trips this run; saturates at all-ones

Behaviour:
- One clock (ck). Reset (res) is synchronous and active-high; it overrides every other input.
- All outputs are registered. On reset: sclr=0, step=0, busy=0, done=0, sweeps=0, state=IDLE, prescaler=0, up_prev=1.
- States: IDLE, CLR, RUN, HOLD, DONE.
- Input priority each cycle: res > stop > start > pause.
- IDLE: all outputs 0 except sweeps, which holds its last value. start -> CLR.
- CLR (exactly 1 cycle): sclr=1. Latch div_l=div and ns_l=nsweep. Clear prescaler and sweeps. Force up_prev=1. Next state RUN.
- RUN:
  - Prescaler increments each cycle. When prescaler==div_l it wraps to 0 and step=1 in the next cycle. Step spacing is exactly div_l+1 cycles; div_l=0 gives step every cycle.
  - First step is asserted div_l+1 cycles after leaving CLR.
  - up_prev<=up_in every cycle. A rising edge (up_prev=0, up_in=1) marks one completed round trip and increments sweeps (saturating).
  - If ns_l!=0 and the incremented count equals ns_l: next state DONE. Any step due in that same cycle is suppressed.
- Event handling from RUN:
  - pause -> HOLD: prescaler frozen, step=0.
  - stop -> IDLE.
  - start -> CLR, which re-latches div and nsweep (restart).
- HOLD:
  - Prescaler and up_prev are frozen.
  - pause low -> RUN, resuming the count where it stopped, with no extra or lost step.
  - stop -> IDLE; start -> CLR.
  - A rising edge of up_in while in HOLD is ignored, since the scanner does not move without step.
- DONE: done=1 and sweeps held. Stays until start -> CLR or stop -> IDLE.
- busy and done are never high together. sclr and step are never high together.
- div or nsweep changes mid-run have no effect until the next start.
- A reset mid-run returns to IDLE with all outputs 0 on the next cycle.

Decomposition:
- Shared header knight_defs.vh holds: state encodings (IDLE=0, CLR=1, RUN=2, HOLD=3, DONE=4, 3 bits) and default widths DIV_W/CNT_W.
- One sub-module, knight_tick:
  - Ports: ck, res, clr, en, div_l; output tick.
  - Behaviour: a loadable prescaler producing one-cycle ticks every div_l+1 enabled cycles.
- The FSM, edge detector and sweep counter stay in knight_seq.

Test Plan:
- Reset: res=1 for 2 cycles with start=1 -> all outputs 0, state IDLE. Release res with start=1 -> sclr=1 for exactly 1 cycle, then busy=1.
- Rate: div=3, nsweep=0 -> step high 1 cycle in 4, first step 4 cycles after CLR. Over 40 RUN cycles, exactly 10 steps.
- Count/complete: div=0, nsweep=2, with a knight scanner model on sclr/step/up -> sweeps goes 1 then 2, done=1, busy=0. No step is issued after the second up rise.
- Pause: div=3; raise pause 2 cycles after a step for 10 cycles -> no step during HOLD. The next step arrives exactly 2 cycles after pause falls, and total spacing excludes the held cycles.
- Priority: stop=1 and start=1 together in RUN -> IDLE, busy=0. Then start alone in DONE -> CLR pulse, sweeps cleared to 0.
- Saturation/restart: CNT_W=2, nsweep=0, drive 5 up rises -> sweeps stays 3. Assert start mid-run with div=1 -> new period of 2 cycles takes effect after CLR.

Source files
------------

// File: rtl/knight_seq_pkg.sv
// Shared types and default widths for the knight scanner sequencer.
package knight_seq_pkg;

   localparam int DIV_W_DEF = 16;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CLR  = 3'd1,
      ST_RUN  = 3'd2,
      ST_HOLD = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // busy covers every state in which a run is in progress
   function automatic logic is_busy(input state_t s);
      return (s == ST_CLR) || (s == ST_RUN) || (s == ST_HOLD);
   endfunction

endpackage

// File: rtl/knight_tick.sv
// Loadable prescaler: one-cycle tick every div_l+1 enabled cycles.
module knight_tick #(
   parameter int DIV_W = 16
) (
   input  logic             ck,
   input  logic             res,
   input  logic             clr,
   input  logic             en,
   input  logic [DIV_W-1:0] div_l,
   output logic             tick
);

   logic [DIV_W-1:0] r_cnt;
   logic             w_wrap;

   assign w_wrap = (r_cnt == div_l);
   assign tick   = en && w_wrap;

   // Count enabled cycles, wrapping to 0 on the cycle that ticks; frozen while en is low
   always_ff @(posedge ck) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (res || clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/knight_seq.sv
// Sequencer for the 8-LED knight scanner: clear/step generation,
// run/pause/stop control and round-trip sweep counting.
module knight_seq
   import knight_seq_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             ck,
   input  logic             res,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [DIV_W-1:0] div,
   input  logic [CNT_W-1:0] nsweep,
   input  logic             up_in,
   output logic             sclr,
   output logic             step,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sweeps
);

   state_t           r_state;
   state_t           w_next;
   logic [DIV_W-1:0] r_div_l;
   logic [CNT_W-1:0] r_ns_l;
   logic [CNT_W-1:0] r_sweeps;
   logic [CNT_W-1:0] w_sweep_inc;
   logic             r_up_prev;
   logic             r_sclr;
   logic             r_step;
   logic             r_busy;
   logic             r_done;
   logic             w_clr;
   logic             w_run;
   logic             w_rise;
   logic             w_hit;
   logic             w_tick;
   logic             w_step_next;

   // A cycle "runs" when a run is active and no control input overrides it;
   // leaving HOLD with pause low counts as a running cycle, so no step is lost.
   assign w_clr       = (r_state == ST_CLR);
   assign w_run       = ((r_state == ST_RUN) || (r_state == ST_HOLD)) && !stop && !start && !pause;
   assign w_rise      = w_run && !r_up_prev && up_in;
   assign w_sweep_inc = (&r_sweeps) ? r_sweeps : r_sweeps + 1'b1;
   assign w_hit       = w_rise && (r_ns_l != '0) && (w_sweep_inc == r_ns_l);

   knight_tick #(
      .DIV_W (DIV_W)
   ) u_tick (
      .ck    (ck),
      .res   (res),
      .clr   (w_clr),
      .en    (w_run),
      .div_l (r_div_l),
      .tick  (w_tick)
   );

   // Next-state decode with priority stop > start > pause > sweep completion
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      w_next      = r_state;
      w_step_next = 1'b0;
      case (r_state)
         ST_IDLE: if (!stop && start) w_next = ST_CLR;
         ST_CLR:  w_next = stop ? ST_IDLE : ST_RUN;
         ST_RUN, ST_HOLD: begin
            if (stop)       w_next = ST_IDLE;
            else if (start) w_next = ST_CLR;
            else if (pause) w_next = ST_HOLD;
            else if (w_hit) w_next = ST_DONE;
            else            w_next = ST_RUN;
         end
         ST_DONE: begin
            if (stop)       w_next = ST_IDLE;
            else if (start) w_next = ST_CLR;
         end
         default: w_next = ST_IDLE;
      endcase
      // a tick landing on the completing cycle is dropped because w_next is DONE
      w_step_next = (w_next == ST_RUN) && w_tick;
   end

   // State register
   always_ff @(posedge ck) begin
      if (res) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Run parameters, direction history and sweep counter
   always_ff @(posedge ck) begin
      if (res) begin
         r_div_l   <= '0;
         r_ns_l    <= '0;
         r_up_prev <= 1'b1;
         r_sweeps  <= '0;
      end else begin
         if (w_next == ST_CLR) begin
            r_div_l  <= div;
            r_ns_l   <= nsweep;
            r_sweeps <= '0;
         end else if (w_rise) begin
            r_sweeps <= w_sweep_inc;
         end
         if (w_clr)      r_up_prev <= 1'b1;
         else if (w_run) r_up_prev <= up_in;
      end
   end

   // Registered outputs decoded from the next state
   always_ff @(posedge ck) begin
      if (res) begin
         r_sclr <= 1'b0;
         r_step <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_sclr <= (w_next == ST_CLR);
         r_step <= w_step_next;
         r_busy <= is_busy(w_next);
         r_done <= (w_next == ST_DONE);
      end
   end

   assign sclr   = r_sclr;
   assign step   = r_step;
   assign busy   = r_busy;
   assign done   = r_done;
   assign sweeps = r_sweeps;

endmodule

// File: tb/tb_knight_seq.sv
// Self-checking bench for knight_seq with a knight scanner model on sclr/step/up.
module tb_knight_seq;

   logic        ck = 1'b0;
   logic        res, start, stop, pause;
   logic [15:0] div;
   logic [7:0]  nsweep;
   logic        up_in;
   logic        sclr, step, busy, done;
   logic [7:0]  sweeps;

   logic        use_scn, up_drv;
   int          scn_pos = 0;
   logic        scn_up  = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state (modes, not RTL encodings)
   localparam int M_IDLE = 0, M_CLEAR = 1, M_ACTIVE = 2, M_DONE = 3;
   int   m_mode = M_IDLE, m_div = 0, m_ns = 0, m_cnt = 0, m_sw = 0;
   logic m_up_last = 1'b1;
   logic e_sclr = 0, e_step = 0, e_busy = 0, e_done = 0;

   assign up_in = use_scn ? scn_up : up_drv;

   always #5 ck = ~ck;

   knight_seq #(.DIV_W(16), .CNT_W(8)) u_dut (
      .ck(ck), .res(res), .start(start), .stop(stop), .pause(pause),
      .div(div), .nsweep(nsweep), .up_in(up_in),
      .sclr(sclr), .step(step), .busy(busy), .done(done), .sweeps(sweeps)
   );

   // 8-LED knight scanner: bounces 0..7, up flag rises on returning to 0
   always @(posedge ck) begin
      if (sclr) begin
         scn_pos <= 0;
         scn_up  <= 1'b1;
      end else if (step) begin
         if (scn_up) begin
            if (scn_pos == 6) scn_up <= 1'b0;
            scn_pos <= scn_pos + 1;
         end else begin
            if (scn_pos == 1) scn_up <= 1'b1;
            scn_pos <= scn_pos - 1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_start(input int d, input int ns);
      div = 16'(d); nsweep = 8'(ns); start = 1'b1;
      @(negedge ck);
      start = 1'b0;
   endtask

   task automatic stop_run();
      stop = 1'b1;
      @(negedge ck);
      stop = 1'b0;
   endtask

   task automatic test_reset();
      res = 1'b1; start = 1'b1;
      repeat (2) @(negedge ck);
      n_checks++; if ({sclr, step, busy, done, sweeps} !== 12'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 000", {sclr, step, busy, done, sweeps}); end
      res = 1'b0;
      @(negedge ck);
      n_checks++; if ({sclr, busy} !== 2'b11) begin n_fail++; $display("FAIL reset_release_clr: sclr,busy got %b expected 11", {sclr, busy}); end
      start = 1'b0;
      @(negedge ck);
      n_checks++; if ({sclr, busy} !== 2'b01) begin n_fail++; $display("FAIL clr_one_cycle: sclr,busy got %b expected 01", {sclr, busy}); end
      stop_run();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_stop_idle: busy got %b expected 0", busy); end
   endtask

   task automatic test_rate();
      int first = -1, cnt = 0, last = -1, min_sp = 1000, max_sp = 0;
      do_start(3, 0);
      for (int n = 1; n <= 60; n++) begin
         @(negedge ck);
         if (step === 1'b1) begin
            if (first < 0) first = n;
            if (n < first + 40) begin
               cnt++;
               if (last >= 0) begin
                  if (n - last < min_sp) min_sp = n - last;
                  if (n - last > max_sp) max_sp = n - last;
               end
               last = n;
            end
         end
      end
      // prescaler is 0 in the first RUN cycle and wraps after div+1 cycles
      n_checks++; if (first !== 5) begin n_fail++; $display("FAIL rate_first_step: got cycle %0d expected 5", first); end
      n_checks++; if (cnt !== 10) begin n_fail++; $display("FAIL rate_step_count: got %0d expected 10", cnt); end
      n_checks++; if (min_sp !== 4 || max_sp !== 4) begin n_fail++; $display("FAIL rate_spacing: got %0d..%0d expected 4..4", min_sp, max_sp); end
      stop_run();
   endtask

   task automatic test_count_complete();
      int   rises = 0, rise_n = 1000, late = 0, done_n = -1, seen1 = 0;
      logic prev_up = 1'b1;
      do_start(0, 2);
      for (int n = 1; n <= 80; n++) begin
         @(negedge ck);
         if (up_in && !prev_up) begin rises++; if (rises == 2) rise_n = n; end
         prev_up = up_in;
         if (sweeps === 8'd1) seen1 = 1;
         if (n > rise_n && step === 1'b1) late++;
         if (done === 1'b1 && done_n < 0) done_n = n;
      end
      n_checks++; if (seen1 !== 1) begin n_fail++; $display("FAIL count_sweep_one: sweeps never read 1"); end
      n_checks++; if (rises !== 2) begin n_fail++; $display("FAIL count_rises: got %0d expected 2", rises); end
      n_checks++; if (late !== 0) begin n_fail++; $display("FAIL count_late_step: got %0d steps after 2nd rise expected 0", late); end
      n_checks++; if (done_n !== rise_n + 1) begin n_fail++; $display("FAIL count_done_time: got cycle %0d expected %0d", done_n, rise_n + 1); end
      n_checks++; if ({done, busy, sweeps} !== {2'b10, 8'd2}) begin n_fail++; $display("FAIL count_final: done,busy,sweeps got %b,%b,%0d expected 1,0,2", done, busy, sweeps); end
      stop_run();
   endtask

   task automatic test_pause();
      int held_steps = 0, busy_low = 0, gap_steps = 0;
      do_start(3, 0);
      for (int i = 0; i < 20 && step !== 1'b1; i++) @(negedge ck);
      n_checks++; if (step !== 1'b1) begin n_fail++; $display("FAIL pause_first_step: got %b expected 1", step); end
      repeat (2) @(negedge ck);
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge ck);
         if (step !== 1'b0) held_steps++;
         if (busy !== 1'b1) busy_low++;
      end
      pause = 1'b0;
      n_checks++; if (held_steps !== 0) begin n_fail++; $display("FAIL pause_held_steps: got %0d expected 0", held_steps); end
      n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL pause_busy: got %0d low cycles expected 0", busy_low); end
      @(negedge ck);
      n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL pause_resume_early: step got %b expected 0", step); end
      @(negedge ck);
      n_checks++; if (step !== 1'b1) begin n_fail++; $display("FAIL pause_resume_step: step got %b expected 1", step); end
      repeat (3) begin @(negedge ck); if (step !== 1'b0) gap_steps++; end
      @(negedge ck);
      n_checks++; if ({gap_steps[1:0], step} !== 3'b001) begin n_fail++; $display("FAIL pause_period_after: gap steps %0d step %b expected 0,1", gap_steps, step); end
      stop_run();
   endtask

   task automatic test_priority();
      do_start(1, 0);
      repeat (3) @(negedge ck);
      stop = 1'b1; start = 1'b1;
      @(negedge ck);
      stop = 1'b0; start = 1'b0;
      n_checks++; if ({busy, sclr, step} !== 3'b000) begin n_fail++; $display("FAIL prio_stop_over_start: busy,sclr,step got %b expected 000", {busy, sclr, step}); end
      @(negedge ck);
      n_checks++; if ({busy, sclr} !== 2'b00) begin n_fail++; $display("FAIL prio_stays_idle: busy,sclr got %b expected 00", {busy, sclr}); end
      do_start(0, 1);
      for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge ck);
      n_checks++; if ({done, sweeps} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL prio_reach_done: done,sweeps got %b,%0d expected 1,1", done, sweeps); end
      start = 1'b1;
      @(negedge ck);
      start = 1'b0;
      n_checks++; if ({sclr, done, busy} !== 3'b101) begin n_fail++; $display("FAIL done_restart_clr: sclr,done,busy got %b expected 101", {sclr, done, busy}); end
      n_checks++; if (sweeps !== 8'd0) begin n_fail++; $display("FAIL done_restart_sweeps: got %0d expected 0", sweeps); end
      stop_run();
   endtask

   task automatic test_saturation_restart();
      logic [10:1] got_steps, exp_steps;
      use_scn = 1'b0; up_drv = 1'b1;
      do_start(2, 0);
      @(negedge ck);
      for (int r = 1; r <= 300; r++) begin
         up_drv = 1'b0;
         @(negedge ck);
         up_drv = 1'b1;
         @(negedge ck);
         if (r == 5) begin
            n_checks++; if (sweeps !== 8'd5) begin n_fail++; $display("FAIL sat_count_5: got %0d expected 5", sweeps); end
         end
      end
      n_checks++; if (sweeps !== 8'd255) begin n_fail++; $display("FAIL sat_hold_max: got %0d expected 255", sweeps); end
      n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL sat_no_done: busy,done got %b expected 10", {busy, done}); end
      do_start(1, 0);
      n_checks++; if ({sclr, sweeps} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL restart_clr: sclr,sweeps got %b,%0d expected 1,0", sclr, sweeps); end
      for (int n = 1; n <= 10; n++) begin
         @(negedge ck);
         got_steps[n] = step;
         exp_steps[n] = (n >= 3) && ((n - 3) % 2 == 0);
      end
      n_checks++; if (got_steps !== exp_steps) begin n_fail++; $display("FAIL restart_period: steps got %b expected %b", got_steps, exp_steps); end
      stop_run();
      use_scn = 1'b1;
   endtask

   task automatic model_clear();
      m_mode = M_CLEAR; m_sw = 0; m_div = int'(div); m_ns = int'(nsweep);
   endtask

   // One clock of the sequencer's rules applied to the inputs of the current cycle
   task automatic model_eval();
      e_step = 1'b0;
      if (res) begin
         m_mode = M_IDLE; m_sw = 0; m_cnt = 0; m_up_last = 1'b1;
      end else begin
         case (m_mode)
            M_IDLE:  if (!stop && start) model_clear();
            M_CLEAR: begin m_cnt = 0; m_up_last = 1'b1; m_mode = stop ? M_IDLE : M_ACTIVE; end
            M_ACTIVE: begin
               if (stop) m_mode = M_IDLE;
               else if (start) model_clear();
               else if (!pause) begin
                  m_cnt++;
                  if (!m_up_last && up_in) begin
                     if (m_sw < 255) m_sw++;
                     if (m_ns != 0 && m_sw == m_ns) m_mode = M_DONE;
                  end
                  m_up_last = up_in;
                  if (m_mode == M_ACTIVE && (m_cnt % (m_div + 1)) == 0) e_step = 1'b1;
               end
            end
            default: begin
               if (stop) m_mode = M_IDLE;
               else if (start) model_clear();
            end
         endcase
      end
      e_sclr = (m_mode == M_CLEAR);
      e_busy = (m_mode == M_CLEAR) || (m_mode == M_ACTIVE);
      e_done = (m_mode == M_DONE);
   endtask

   task automatic test_random();
      logic [11:0] exp_v;
      for (int i = 0; i < 3000; i++) begin
         if (i > 0) begin
            exp_v = {e_sclr, e_step, e_busy, e_done, 8'(m_sw)};
            n_checks++; if ({sclr, step, busy, done, sweeps} !== exp_v) begin n_fail++; $display("FAIL random_outputs cycle %0d: sclr,step,busy,done,sweeps got %h expected %h", i, {sclr, step, busy, done, sweeps}, exp_v); end
            n_checks++; if ((busy && done) || (sclr && step)) begin n_fail++; $display("FAIL random_exclusive cycle %0d: busy,done,sclr,step got %b expected no pair high", i, {busy, done, sclr, step}); end
         end
         res    = (i < 2) || ($urandom_range(0, 999) == 0);
         start  = ($urandom_range(0, 199) == 0);
         stop   = ($urandom_range(0, 399) == 0);
         if (pause) pause = ($urandom_range(0, 3) != 0);
         else       pause = ($urandom_range(0, 29) == 0);
         div    = 16'($urandom_range(0, 4));
         nsweep = 8'($urandom_range(0, 3));
         model_eval();
         @(negedge ck);
      end
      res = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
   endtask

   initial begin
      res = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
      div = '0; nsweep = '0; use_scn = 1'b1; up_drv = 1'b1;
      test_reset();
      test_rate();
      test_count_complete();
      test_pause();
      test_priority();
      test_saturation_restart();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
